// File: rtl/riscv_defines.sv
// -----------------------------------------------------------------------------
// riscv_defines
// Shared constants and types for the multi-cycle bitops sequencer.
//   BIT_OP_WIDTH   : width of the bitops operator select
//   BITOP_*        : operator encodings (CNT, FF1, FL1, PAR)
//   BITOPS_DATA_W  : operand / result width
//   BITOPS_ACC_W   : accumulator width (holds 0..32)
//   bitops_state_e : sequencer FSM states
// -----------------------------------------------------------------------------
package riscv_defines;

   localparam int BIT_OP_WIDTH  = 2;
   localparam int BITOPS_DATA_W = 32;
   localparam int BITOPS_ACC_W  = 6;

   localparam logic [BIT_OP_WIDTH-1:0] BITOP_CNT = 2'b00;
   localparam logic [BIT_OP_WIDTH-1:0] BITOP_FF1 = 2'b01;
   localparam logic [BIT_OP_WIDTH-1:0] BITOP_FL1 = 2'b10;
   localparam logic [BIT_OP_WIDTH-1:0] BITOP_PAR = 2'b11;

   typedef enum logic [1:0] {
      BITOPS_IDLE = 2'b00,
      BITOPS_SCAN = 2'b01,
      BITOPS_DONE = 2'b10
   } bitops_state_e;

endpackage

// File: rtl/riscv_bitops_chunk.sv
// -----------------------------------------------------------------------------
// riscv_bitops_chunk
// Purely combinational per-chunk statistics used by the sequencer each cycle.
//   data_i     : CHUNK_W-bit slice of the operand
//   popcnt_o   : number of set bits
//   parity_o   : XOR of all bits
//   nonzero_o  : any bit set
//   lo_idx_o   : index of the lowest set bit (0 when the chunk is zero)
//   hi_idx_o   : index of the highest set bit (0 when the chunk is zero)
// -----------------------------------------------------------------------------
module riscv_bitops_chunk #(
   parameter int CHUNK_W = 8,
   parameter int CNT_W   = $clog2(CHUNK_W + 1),
   parameter int IDX_W   = $clog2(CHUNK_W)
) (
   input  logic [CHUNK_W-1:0] data_i,
   output logic [CNT_W-1:0]   popcnt_o,
   output logic               parity_o,
   output logic               nonzero_o,
   output logic [IDX_W-1:0]   lo_idx_o,
   output logic [IDX_W-1:0]   hi_idx_o
);

   always_comb begin
      popcnt_o = '0;
      for (int i = 0; i < CHUNK_W; i++) begin
         popcnt_o = popcnt_o + CNT_W'(data_i[i]);
      end
   end

   assign parity_o  = ^data_i;
   assign nonzero_o = |data_i;

   // Scan high-to-low so the last hit written is the lowest set bit.
   always_comb begin
      lo_idx_o = '0;
      for (int i = CHUNK_W - 1; i >= 0; i--) begin
         if (data_i[i]) lo_idx_o = IDX_W'(i);
      end
   end

   // Scan low-to-high so the last hit written is the highest set bit.
   always_comb begin
      hi_idx_o = '0;
      for (int i = 0; i < CHUNK_W; i++) begin
         if (data_i[i]) hi_idx_o = IDX_W'(i);
      end
   end

endmodule

// File: rtl/riscv_bitops_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_bitops_ctrl
// Multi-cycle sequencer for the EX-stage bitops unit. Accepts one operation
// in IDLE, scans the 32-bit operand one CHUNK_W-bit chunk per cycle (FF1/FL1
// exit early on the first non-zero chunk), then holds the result in DONE
// until EX/WB takes it.
//   clk, rst_n    : clock, asynchronous active-low reset
//   enable_i      : operation request (sampled in IDLE only)
//   operator_i    : BITOP_* select
//   operand_i     : source operand, captured on accept
//   flush_i       : abort current operation, return to IDLE
//   ex_ready_i    : downstream takes the result this cycle
//   ready_o       : EX may advance (combinational)
//   valid_o       : result_o valid (DONE)
//   result_o      : zero-extended result
//   bitops_en_o   : enable to riscv_bitops, high while scanning
//   bitops_op_o   : latched operator to riscv_bitops
// CHUNK_W must divide 32.
// -----------------------------------------------------------------------------
module riscv_bitops_ctrl
   import riscv_defines::*;
#(
   parameter int CHUNK_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable_i,
   input  logic [BIT_OP_WIDTH-1:0]  operator_i,
   input  logic [BITOPS_DATA_W-1:0] operand_i,
   input  logic                     flush_i,
   input  logic                     ex_ready_i,
   output logic                     ready_o,
   output logic                     valid_o,
   output logic [BITOPS_DATA_W-1:0] result_o,
   output logic                     bitops_en_o,
   output logic [BIT_OP_WIDTH-1:0]  bitops_op_o
);

   localparam int NUM_CHUNKS = BITOPS_DATA_W / CHUNK_W;
   localparam int CIDX_W     = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam int CNT_W      = $clog2(CHUNK_W + 1);
   localparam int BIDX_W     = $clog2(CHUNK_W);
   localparam logic [CIDX_W-1:0] LAST_CHUNK = CIDX_W'(NUM_CHUNKS - 1);

   bitops_state_e               state_q, state_d;
   logic [BIT_OP_WIDTH-1:0]     op_q, op_d;
   logic [BITOPS_DATA_W-1:0]    operand_q, operand_d;
   logic [BITOPS_ACC_W-1:0]     acc_q, acc_d;
   logic [CIDX_W-1:0]           idx_q, idx_d;

   // Chunk selection
   logic [CHUNK_W-1:0] chunk_arr [NUM_CHUNKS];
   logic [CHUNK_W-1:0] chunk_cur;

   generate
      for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
         assign chunk_arr[gi] = operand_q[gi*CHUNK_W +: CHUNK_W];
      end
   endgenerate

   assign chunk_cur = chunk_arr[idx_q];

   logic [CNT_W-1:0]  chunk_cnt;
   logic              chunk_par;
   logic              chunk_nz;
   logic [BIDX_W-1:0] chunk_lo;
   logic [BIDX_W-1:0] chunk_hi;

   riscv_bitops_chunk #(
      .CHUNK_W (CHUNK_W),
      .CNT_W   (CNT_W),
      .IDX_W   (BIDX_W)
   ) u_chunk (
      .data_i    (chunk_cur),
      .popcnt_o  (chunk_cnt),
      .parity_o  (chunk_par),
      .nonzero_o (chunk_nz),
      .lo_idx_o  (chunk_lo),
      .hi_idx_o  (chunk_hi)
   );

   // Absolute bit positions of the lowest/highest set bit in the current chunk
   logic [BITOPS_ACC_W-1:0] chunk_base;
   logic                    is_find;
   logic                    last_chunk;

   assign chunk_base = BITOPS_ACC_W'(idx_q) * BITOPS_ACC_W'(CHUNK_W);
   assign is_find    = (op_q == BITOP_FF1) || (op_q == BITOP_FL1);
   // FL1 walks downward, everything else upward.
   assign last_chunk = (op_q == BITOP_FL1) ? (idx_q == '0) : (idx_q == LAST_CHUNK);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      operand_d = operand_q;
      acc_d     = acc_q;
      idx_d     = idx_q;

      if (flush_i) begin
         state_d = BITOPS_IDLE;
         acc_d   = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            BITOPS_IDLE: begin
               if (enable_i) begin
                  op_d      = operator_i;
                  operand_d = operand_i;
                  acc_d     = '0;
                  idx_d     = (operator_i == BITOP_FL1) ? LAST_CHUNK : '0;
                  state_d   = BITOPS_SCAN;
               end
            end

            BITOPS_SCAN: begin
               unique case (op_q)
                  BITOP_CNT: acc_d = acc_q + BITOPS_ACC_W'(chunk_cnt);
                  BITOP_PAR: acc_d = {acc_q[BITOPS_ACC_W-1:1], acc_q[0] ^ chunk_par};
                  BITOP_FF1: if (chunk_nz) acc_d = chunk_base + BITOPS_ACC_W'(chunk_lo);
                  BITOP_FL1: if (chunk_nz) acc_d = chunk_base + BITOPS_ACC_W'(chunk_hi);
                  default:   acc_d = acc_q;
               endcase

               if (is_find && chunk_nz) begin
                  state_d = BITOPS_DONE;
               end else if (last_chunk) begin
                  state_d = BITOPS_DONE;
                  // No set bit anywhere: find ops report the full width.
                  if (is_find) acc_d = BITOPS_ACC_W'(BITOPS_DATA_W);
               end else begin
                  idx_d = (op_q == BITOP_FL1) ? idx_q - 1'b1 : idx_q + 1'b1;
               end
            end

            BITOPS_DONE: begin
               if (ex_ready_i) state_d = BITOPS_IDLE;
            end

            default: state_d = BITOPS_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= BITOPS_IDLE;
         op_q      <= '0;
         operand_q <= '0;
         acc_q     <= '0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         acc_q     <= acc_d;
         idx_q     <= idx_d;
      end
   end

   assign ready_o     = ((state_q == BITOPS_IDLE) && !enable_i) ||
                        ((state_q == BITOPS_DONE) && ex_ready_i);
   assign valid_o     = (state_q == BITOPS_DONE);
   assign bitops_en_o = (state_q == BITOPS_SCAN);
   assign bitops_op_o = op_q;
   assign result_o    = {{(BITOPS_DATA_W-BITOPS_ACC_W){1'b0}}, acc_q};

endmodule

// File: doc/riscv_bitops_ctrl.md
# riscv_bitops_ctrl

Multi-cycle sequencer for the custom bitops unit in the EX stage. It accepts one bit-manipulation operation at a time from the ID/EX pipeline and scans the 32-bit operand in 8-bit chunks, one chunk per cycle, exiting early where the operation allows. It stalls EX via `ready_o` until the result is consumed, and drives the enable/operator inputs of `riscv_bitops` while scanning.

## Interface
Parameters:
- `CHUNK_W`, 8: bits processed per cycle; must divide 32.

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous, active-low reset
- `enable_i`  in  1  operation request from ID/EX; sampled in IDLE only
- `operator_i`  in  `BIT_OP_WIDTH`  operation select
- `operand_i`  in  32  source operand; captured on accept
- `flush_i`  in  1  abort the current operation (pipeline flush)
- `ex_ready_i`  in  1  EX/WB can take the result this cycle
- `ready_o`  out  1  high when EX may advance (not busy)
- `valid_o`  out  1  `result_o` is valid
- `result_o`  out  32  result, zero-extended
- `bitops_en_o`  out  1  enable to `riscv_bitops`; high in SCAN
- `bitops_op_o`  out  `BIT_OP_WIDTH`  latched operator to `riscv_bitops`

## Operation
- Operators (`riscv_defines`):
  - `BITOP_CNT`: popcount.
  - `BITOP_FF1`: index of the lowest set bit.
  - `BITOP_FL1`: index of the highest set bit.
  - `BITOP_PAR`: XOR of all bits.
- FSM states: IDLE, SCAN, DONE.
- IDLE, `enable_i`=1 and `flush_i`=0:
  - latch operand and operator; clear the accumulator.
  - chunk index = 3 for FL1, otherwise 0.
  - go to SCAN.
- SCAN, one chunk per cycle:
  - CNT: accumulator += chunk popcount.
  - PAR: accumulator[0] ^= chunk parity.
  - FF1: scan chunks 0→3. On the first non-zero chunk k, result = k*8 + lowest set bit; go to DONE.
  - FL1: scan chunks 3→0. On the first non-zero chunk k, result = k*8 + highest set bit; go to DONE.
  - After the last chunk, go to DONE. FF1/FL1 with an all-zero operand return 32.
- DONE:
  - `valid_o`=1; `result_o` held stable.
  - `ex_ready_i`=1 → IDLE.
- `flush_i`=1 in any state → IDLE on the next edge, accumulator cleared, `valid_o` not asserted for the aborted op. Flush has priority over `enable_i` and `ex_ready_i`.
- `enable_i` in SCAN/DONE is ignored; ID holds the request while `ready_o`=0.
- Arithmetic width: accumulator is 6 bits (max 32); `result_o[31:6]` = 0.

## Timing
- `ready_o` = (IDLE & !`enable_i`) | (DONE & `ex_ready_i`); this output is combinational.
- Latency from accept edge to `valid_o`:
  - CNT, PAR, and zero-operand FF1/FL1: 4 SCAN cycles, `valid_o` in cycle 5.
  - FF1/FL1 hitting chunk at scan position p (0-based): p+1 SCAN cycles.
- No back-to-back issue: a new op is accepted earliest the cycle after DONE→IDLE.
- Reset values: state IDLE, `valid_o`=0, `result_o`=0, `bitops_en_o`=0, `bitops_op_o`=0, accumulator 0, chunk index 0.
- Reset asserted mid-SCAN: immediate return to IDLE with the reset values.

## Structure
- `riscv_defines` holds:
  - `BIT_OP_WIDTH`=2.
  - encodings `BITOP_CNT`=2'b00, `BITOP_FF1`=2'b01, `BITOP_FL1`=2'b10, `BITOP_PAR`=2'b11.
  - `bitops_state_e` enum.
- One sub-module, `riscv_bitops_chunk`: combinational, `CHUNK_W`-bit input. Outputs popcount, parity, nonzero, lowest-set index, highest-set index.
- FSM, chunk counter and accumulator stay in `riscv_bitops_ctrl`.

## Test plan
- CNT 0xFFFF_0F01 → `ready_o` low 5 cycles; `valid_o` in cycle 5 with 21; returns to IDLE on `ex_ready_i`.
- FF1 0x0000_0100 → `valid_o` after 2 SCAN cycles, result 8. FF1 0x0000_0000 → 4 SCAN cycles, result 32.
- FL1 0x8000_0000 → 1 SCAN cycle, result 31. FL1 0x0000_0001 → 4 SCAN cycles, result 0.
- PAR 0x0000_0007 → 1; `ex_ready_i` held low 3 cycles → `valid_o`/`result_o` stable, `ready_o` low until release.
- `flush_i` in the 2nd SCAN cycle of CNT → IDLE next cycle, no `valid_o`. The next op (PAR 0x1) completes normally with result 1.
- `rst_n` low mid-SCAN → all outputs at reset values asynchronously. After release, FF1 0x10 → 4.
